// File: rtl/mem_stage_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl_if
//  Description : Bundle between the EXE/MEM pipeline register, the memory-stage
//                SRAM controller and the external 16-bit SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    // Pipeline side
    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        ALU_result;
    logic [31:0]        ST_val;
    logic [31:0]        rdata;
    logic               ready;
    // SRAM side
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_o;
    logic [15:0]        sram_dq_i;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;

    // Pipeline + SRAM environment view
    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_result, ST_val, sram_dq_i,
        input  rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
    );

    // Controller view
    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val, sram_dq_i,
        output rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl
//  Description : Memory-stage controller. Splits each 32-bit load/store into
//                a low and a high 16-bit SRAM access, holds ready low while
//                busy, and returns assembled 32-bit load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl #(
    parameter int BASE_ADDR     = 1024,
    parameter int SRAM_AW       = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mem_stage_sram_ctrl_if.slave   bus
);

    localparam int c_CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_store;
    logic [SRAM_AW-2:0] r_idx;
    logic [15:0]        r_st_hi;
    logic [15:0]        r_lo_data;
    logic [31:0]        r_rdata;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_sram_dq_o;
    logic               r_sram_dq_oe;
    logic               r_sram_we_n;
    logic               r_sram_oe_n;

    logic               w_req;
    logic               w_last;
    logic [SRAM_AW-2:0] w_idx;

    assign w_req  = bus.MEM_R_EN | bus.MEM_W_EN;
    assign w_last = (r_cnt == c_CNT_W'(ACCESS_CYCLES - 1));
    // Word index relative to the base; wraps modulo the SRAM size by truncation.
    assign w_idx  = (SRAM_AW-1)'((bus.ALU_result - 32'(BASE_ADDR)) >> 2);

    // Access sequencer: latches the request, walks LO -> HI -> DONE, drives registered SRAM strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_is_store   <= 1'b0;
            r_idx        <= '0;
            r_st_hi      <= 16'h0000;
            r_lo_data    <= 16'h0000;
            r_rdata      <= 32'h0000_0000;
            r_sram_addr  <= '0;
            r_sram_dq_o  <= 16'h0000;
            r_sram_dq_oe <= 1'b0;
            r_sram_we_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        // Store wins when both enables are set.
                        r_state     <= c_LO;
                        r_cnt       <= '0;
                        r_is_store  <= bus.MEM_W_EN;
                        r_idx       <= w_idx;
                        r_st_hi     <= bus.ST_val[31:16];
                        r_sram_addr <= {w_idx, 1'b0};
                        if (bus.MEM_W_EN) begin
                            r_sram_dq_o  <= bus.ST_val[15:0];
                            r_sram_dq_oe <= 1'b1;
                            r_sram_we_n  <= 1'b0;
                            r_sram_oe_n  <= 1'b1;
                        end else begin
                            r_sram_dq_oe <= 1'b0;
                            r_sram_we_n  <= 1'b1;
                            r_sram_oe_n  <= 1'b0;
                        end
                    end
                end
                c_LO: begin
                    if (w_last) begin
                        r_state     <= c_HI;
                        r_cnt       <= '0;
                        r_sram_addr <= {r_idx, 1'b1};
                        if (r_is_store) begin
                            r_sram_dq_o <= r_st_hi;
                        end else begin
                            r_lo_data <= bus.sram_dq_i;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_HI: begin
                    if (w_last) begin
                        r_state      <= c_DONE;
                        r_cnt        <= '0;
                        r_sram_dq_oe <= 1'b0;
                        r_sram_we_n  <= 1'b1;
                        r_sram_oe_n  <= 1'b1;
                        if (!r_is_store) begin
                            r_rdata <= {bus.sram_dq_i, r_lo_data};
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Pipeline may advance when idle with nothing requested, or on the completion cycle.
    assign bus.ready      = ((r_state == c_IDLE) && !w_req) || (r_state == c_DONE);
    assign bus.rdata      = r_rdata;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_dq_o  = r_sram_dq_o;
    assign bus.sram_dq_oe = r_sram_dq_oe;
    assign bus.sram_we_n  = r_sram_we_n;
    assign bus.sram_oe_n  = r_sram_oe_n;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_sram_ctrl
//  Description : Directed self-checking bench for mem_stage_sram_ctrl with a
//                small behavioural SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

    localparam int BASE    = 1024;
    localparam int AW      = 18;
    localparam int AC      = 2;
    localparam int BUSY    = 2 * AC + 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_stage_sram_ctrl_if #(.SRAM_AW(AW)) bus ();

    mem_stage_sram_ctrl #(
        .BASE_ADDR     (BASE),
        .SRAM_AW       (AW),
        .ACCESS_CYCLES (AC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: a write commits only once the strobe has been held AC cycles on one address.
    logic [15:0]   mem [0:63];
    logic [AW-1:0] wr_addr;
    int            wr_hold;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[9]  = 16'hBEEF;
        wr_hold = 0;
        wr_addr = '0;
    end

    always @(posedge clk) begin
        if (!bus.sram_we_n && bus.sram_dq_oe) begin
            if (wr_hold > 0 && bus.sram_addr == wr_addr) begin
                wr_hold = wr_hold + 1;
            end else begin
                wr_hold = 1;
                wr_addr = bus.sram_addr;
            end
            if (wr_hold == AC) mem[bus.sram_addr[5:0]] = bus.sram_dq_o;
        end else begin
            wr_hold = 0;
        end
    end

    assign bus.sram_dq_i = (!bus.sram_oe_n) ? mem[bus.sram_addr[5:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one access and run it to its DONE cycle; returns with the DUT in DONE.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input string tag);
        int lowcnt;
        int wecnt;
        int oecnt;
        lowcnt = 0;
        wecnt  = 0;
        oecnt  = 0;
        bus.MEM_R_EN   = rd;
        bus.MEM_W_EN   = wr;
        bus.ALU_result = addr;
        bus.ST_val     = data;
        #1;
        if (bus.ready) begin
            // Issued during DONE: the following IDLE cycle must already stall.
            step();
            check({tag, "_b2b_idle_ready"}, {31'd0, bus.ready}, 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            if (bus.ready) break;
            lowcnt++;
            if (!bus.sram_we_n) wecnt++;
            if (!bus.sram_oe_n) oecnt++;
            step();
        end
        check({tag, "_busy_cycles"}, lowcnt, BUSY);
        check({tag, "_we_cycles"}, wecnt, wr ? 2 * AC : 0);
        check({tag, "_oe_cycles"}, oecnt, (rd && !wr) ? 2 * AC : 0);
    endtask

    task automatic end_op();
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
        step();
    endtask

    initial begin
        int guard;
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.MEM_R_EN   = 1'b0;
        bus.MEM_W_EN   = 1'b0;
        bus.ALU_result = 32'd0;
        bus.ST_val     = 32'd0;
        step();
        step();
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_we_n", {31'd0, bus.sram_we_n}, 32'd1);
        check("rst_oe_n", {31'd0, bus.sram_oe_n}, 32'd1);
        check("rst_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_addr", {14'd0, bus.sram_addr}, 32'd0);
        rst = 1'b0;
        step();

        // Store 0x12345678 @1028
        do_op(1'b0, 1'b1, 32'd1028, 32'h1234_5678, "st1");
        check("st1_done_ready", {31'd0, bus.ready}, 32'd1);
        end_op();
        check("st1_idle_ready", {31'd0, bus.ready}, 32'd1);
        check("st1_mem2", {16'd0, mem[2]}, 32'h0000_5678);
        check("st1_mem3", {16'd0, mem[3]}, 32'h0000_1234);
        check("st1_rdata", bus.rdata, 32'd0);

        // Load @1028
        do_op(1'b1, 1'b0, 32'd1028, 32'h0, "ld1");
        check("ld1_rdata", bus.rdata, 32'h1234_5678);
        end_op();

        // Store then back-to-back load @1032
        do_op(1'b0, 1'b1, 32'd1032, 32'hCAFE_BABE, "st2");
        check("st2_rdata_held", bus.rdata, 32'h1234_5678);
        do_op(1'b1, 1'b0, 32'd1032, 32'h0, "ld2");
        check("ld2_rdata", bus.rdata, 32'hCAFE_BABE);
        end_op();
        check("st2_mem4", {16'd0, mem[4]}, 32'h0000_BABE);
        check("st2_mem5", {16'd0, mem[5]}, 32'h0000_CAFE);

        // Both enables -> store @1024
        do_op(1'b1, 1'b1, 32'd1024, 32'hA5A5_0F0F, "both");
        end_op();
        check("both_mem0", {16'd0, mem[0]}, 32'h0000_0F0F);
        check("both_mem1", {16'd0, mem[1]}, 32'h0000_A5A5);
        check("both_rdata", bus.rdata, 32'hCAFE_BABE);

        // Inputs changed and request dropped mid-op: store @1036 still completes as latched
        bus.MEM_W_EN   = 1'b1;
        bus.ALU_result = 32'd1036;
        bus.ST_val     = 32'h0102_0304;
        step();
        bus.MEM_W_EN   = 1'b0;
        bus.ALU_result = 32'd1024;
        bus.ST_val     = 32'hFFFF_FFFF;
        guard = 0;
        while (!bus.ready && guard < 20) begin
            step();
            guard++;
        end
        check("midop_cycles", guard, BUSY - 1);
        step();
        check("midop_mem6", {16'd0, mem[6]}, 32'h0000_0304);
        check("midop_mem7", {16'd0, mem[7]}, 32'h0000_0102);
        check("midop_mem0", {16'd0, mem[0]}, 32'h0000_0F0F);

        // Reset during HI of a store @1040
        bus.MEM_W_EN   = 1'b1;
        bus.ALU_result = 32'd1040;
        bus.ST_val     = 32'h1111_2222;
        step();
        step();
        step();
        check("rsthi_addr", {14'd0, bus.sram_addr}, 32'd9);
        check("rsthi_we_n", {31'd0, bus.sram_we_n}, 32'd0);
        rst          = 1'b1;
        bus.MEM_W_EN = 1'b0;
        step();
        check("rsthi_ready", {31'd0, bus.ready}, 32'd1);
        check("rsthi_we_n_after", {31'd0, bus.sram_we_n}, 32'd1);
        check("rsthi_dq_oe", {31'd0, bus.sram_dq_oe}, 32'd0);
        check("rsthi_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        step();
        check("rsthi_mem8", {16'd0, mem[8]}, 32'h0000_2222);
        check("rsthi_mem9", {16'd0, mem[9]}, 32'h0000_BEEF);

        // Read back the half-written word
        do_op(1'b1, 1'b0, 32'd1040, 32'h0, "ld3");
        check("ld3_rdata", bus.rdata, 32'hBEEF_2222);
        end_op();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
